// File: rtl/mesi_isc_mon_pkg.sv
// mesi_isc_mon_pkg: shared types and constants for the ISC bus monitor.
// Command values mirror the mesi_isc_define.v main-bus encodings.
package mesi_isc_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ACKED = 2'd2
   } mon_state_t;

   localparam int unsigned CMD_LEGAL_MAX = 4;

   localparam int unsigned MESI_ISC_MBUS_CMD_NOP      = 0;
   localparam int unsigned MESI_ISC_MBUS_CMD_WR       = 1;
   localparam int unsigned MESI_ISC_MBUS_CMD_RD       = 2;
   localparam int unsigned MESI_ISC_MBUS_CMD_WR_BROAD = 3;
   localparam int unsigned MESI_ISC_MBUS_CMD_RD_BROAD = 4;

endpackage

// File: rtl/mesi_isc_mon_port.sv
// mesi_isc_mon_port: per-port handshake FSM, timer and sticky errors.
// Completion counter present only with MESI_ISC_MON_STATS_EN.
module mesi_isc_mon_port
   import mesi_isc_mon_pkg::*;
#(
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int CBUS_CMD_WIDTH = 3,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int STAT_WIDTH     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
   input  logic                      mbus_ack_i,
   input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
   input  logic                      clr_i,
   output logic                      err_ack_width_o,
   output logic                      err_spurious_ack_o,
   output logic                      err_timeout_o,
   output logic                      err_cmd_drop_o,
   output logic                      err_cmd_illegal_o,
   output logic [STAT_WIDTH-1:0]     stat_bcast_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

   mon_state_t                state_q, state_d;
   logic [MBUS_CMD_WIDTH-1:0] cmd_q, cmd_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic                      fired_q, fired_d;
   logic                      is_bcast, done;
   logic                      set_aw, set_sp, set_to, set_dr, set_il;

   assign is_bcast =
      (mbus_cmd_i == MBUS_CMD_WIDTH'(MESI_ISC_MBUS_CMD_WR_BROAD)) ||
      (mbus_cmd_i == MBUS_CMD_WIDTH'(MESI_ISC_MBUS_CMD_RD_BROAD));

   assign set_il =
      (mbus_cmd_i > MBUS_CMD_WIDTH'(CMD_LEGAL_MAX)) ||
      (cbus_cmd_i > CBUS_CMD_WIDTH'(CMD_LEGAL_MAX));

   // Handshake FSM state, latched command and timeout timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         timer_q <= '0;
         fired_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         timer_q <= timer_d;
         fired_q <= fired_d;
      end
   end

   // Next state plus one-cycle error set pulses; timeout is judged
   // before the ack so an ack arriving after TIMEOUT_CYCLES still flags.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      timer_d = timer_q;
      fired_d = fired_q;
      done    = 1'b0;
      set_aw  = 1'b0;
      set_sp  = 1'b0;
      set_to  = 1'b0;
      set_dr  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            fired_d = 1'b0;
            if (is_bcast && mbus_ack_i) begin
               state_d = ST_ACKED;
               done    = 1'b1;
            end else if (is_bcast) begin
               state_d = ST_REQ;
               cmd_d   = mbus_cmd_i;
               timer_d = TW'(1);
            end else if (mbus_ack_i) begin
               set_sp = 1'b1;
            end
         end
         ST_REQ: begin
            if (timer_q == TMAX && !fired_q) begin
               set_to  = 1'b1;
               fired_d = 1'b1;
            end
            if (mbus_ack_i) begin
               state_d = ST_ACKED;
               done    = 1'b1;
            end else if (mbus_cmd_i != cmd_q) begin
               state_d = ST_IDLE;
               set_dr  = 1'b1;
            end else if (timer_q != TMAX) begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_ACKED: begin
            set_aw  = mbus_ack_i;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky error flags; a new set wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ack_width_o    <= 1'b0;
         err_spurious_ack_o <= 1'b0;
         err_timeout_o      <= 1'b0;
         err_cmd_drop_o     <= 1'b0;
         err_cmd_illegal_o  <= 1'b0;
      end else begin
         err_ack_width_o    <= set_aw | (err_ack_width_o & ~clr_i);
         err_spurious_ack_o <= set_sp | (err_spurious_ack_o & ~clr_i);
         err_timeout_o      <= set_to | (err_timeout_o & ~clr_i);
         err_cmd_drop_o     <= set_dr | (err_cmd_drop_o & ~clr_i);
         err_cmd_illegal_o  <= set_il | (err_cmd_illegal_o & ~clr_i);
      end
   end

`ifdef MESI_ISC_MON_STATS_EN
   logic [STAT_WIDTH-1:0] cnt_q;

   // Saturating completed-broadcast counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (done && (cnt_q != '1)) begin
         cnt_q <= cnt_q + STAT_WIDTH'(1);
      end
   end

   assign stat_bcast_o = cnt_q;
`else
   logic unused_done;
   assign unused_done  = done;
   assign stat_bcast_o = '0;
`endif

endmodule

// File: rtl/mesi_isc_bus_monitor.sv
// mesi_isc_bus_monitor: run-time protocol checker for NUM_PORTS ISC ports.
// Optional counters: define MESI_ISC_MON_STATS_EN.
module mesi_isc_bus_monitor
   import mesi_isc_mon_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int CBUS_CMD_WIDTH = 3,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int STAT_WIDTH     = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_PORTS*MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
   input  logic [NUM_PORTS-1:0]                mbus_ack_i,
   input  logic [NUM_PORTS*CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
   input  logic                                clr_i,
   output logic [NUM_PORTS-1:0]                err_ack_width_o,
   output logic [NUM_PORTS-1:0]                err_spurious_ack_o,
   output logic [NUM_PORTS-1:0]                err_timeout_o,
   output logic [NUM_PORTS-1:0]                err_cmd_drop_o,
   output logic [NUM_PORTS-1:0]                err_cmd_illegal_o,
   output logic                                err_wr_multi_o,
   output logic                                err_any_o,
   output logic [NUM_PORTS*STAT_WIDTH-1:0]     stat_bcast_o
);

   localparam int MW = MBUS_CMD_WIDTH;
   localparam int CW = CBUS_CMD_WIDTH;

   logic [NUM_PORTS-1:0] is_wr;
   logic                 set_wm;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign is_wr[p] =
         mbus_cmd_i[p*MW +: MW] == MW'(MESI_ISC_MBUS_CMD_WR);

      mesi_isc_mon_port #(
         .MBUS_CMD_WIDTH (MW),
         .CBUS_CMD_WIDTH (CW),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .STAT_WIDTH     (STAT_WIDTH)
      ) u_port (
         .clk                (clk),
         .rst                (rst),
         .mbus_cmd_i         (mbus_cmd_i[p*MW +: MW]),
         .mbus_ack_i         (mbus_ack_i[p]),
         .cbus_cmd_i         (cbus_cmd_i[p*CW +: CW]),
         .clr_i              (clr_i),
         .err_ack_width_o    (err_ack_width_o[p]),
         .err_spurious_ack_o (err_spurious_ack_o[p]),
         .err_timeout_o      (err_timeout_o[p]),
         .err_cmd_drop_o     (err_cmd_drop_o[p]),
         .err_cmd_illegal_o  (err_cmd_illegal_o[p]),
         .stat_bcast_o       (stat_bcast_o[p*STAT_WIDTH +: STAT_WIDTH])
      );
   end

   assign set_wm = $countones(is_wr) > 1;

   // Sticky flag for simultaneous plain writes on several ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_wr_multi_o <= 1'b0;
      end else begin
         err_wr_multi_o <= set_wm | (err_wr_multi_o & ~clr_i);
      end
   end

   assign err_any_o = (|err_ack_width_o) | (|err_spurious_ack_o) |
                      (|err_timeout_o) | (|err_cmd_drop_o) |
                      (|err_cmd_illegal_o) | err_wr_multi_o;

endmodule

// File: tb/tb_mesi_isc_bus_monitor.sv
// tb_mesi_isc_bus_monitor: directed plus random stimulus against an
// in-bench transaction model of the ISC bus monitor.
module tb_mesi_isc_bus_monitor;

   localparam int NP = 4;
   localparam int MW = 3;
   localparam int CW = 3;
   localparam int TO = 8;
   localparam int SW = 4;
`ifdef MESI_ISC_MON_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [NP*MW-1:0] mbus_cmd;
   logic [NP-1:0]    mbus_ack;
   logic [NP*CW-1:0] cbus_cmd;
   logic             clr;
   logic [NP-1:0]    aw, sp, tmo, dr, il;
   logic             wm, any;
   logic [NP*SW-1:0] stat;

   always #5 clk = ~clk;

   mesi_isc_bus_monitor #(
      .NUM_PORTS      (NP),
      .MBUS_CMD_WIDTH (MW),
      .CBUS_CMD_WIDTH (CW),
      .TIMEOUT_CYCLES (TO),
      .STAT_WIDTH     (SW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .mbus_cmd_i         (mbus_cmd),
      .mbus_ack_i         (mbus_ack),
      .cbus_cmd_i         (cbus_cmd),
      .clr_i              (clr),
      .err_ack_width_o    (aw),
      .err_spurious_ack_o (sp),
      .err_timeout_o      (tmo),
      .err_cmd_drop_o     (dr),
      .err_cmd_illegal_o  (il),
      .err_wr_multi_o     (wm),
      .err_any_o          (any),
      .stat_bcast_o       (stat)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Per port: an outstanding broadcast (pending, command, age in cycles
   // since issue), or a just-acked broadcast awaiting its ack to drop.
   bit            m_pend [NP];
   bit            m_acked[NP];
   int            m_age  [NP];
   int            m_pcmd [NP];
   int            m_cnt  [NP];
   logic [NP-1:0] e_aw = '0, e_sp = '0, e_to = '0, e_dr = '0, e_il = '0;
   logic          e_wm = 1'b0;

   function automatic int mcmd(input int p);
      return int'(mbus_cmd[p*MW +: MW]);
   endfunction

   function automatic int ccmd(input int p);
      return int'(cbus_cmd[p*CW +: CW]);
   endfunction

   always @(posedge clk or posedge rst) begin
      int c, nwr;
      bit a, bc, s_aw, s_sp, s_to, s_dr, s_il;
      if (rst) begin
         for (int p = 0; p < NP; p++) begin
            m_pend[p] = 0; m_acked[p] = 0; m_age[p] = 0;
            m_pcmd[p] = 0; m_cnt[p] = 0;
         end
         e_aw = '0; e_sp = '0; e_to = '0; e_dr = '0; e_il = '0;
         e_wm = 1'b0;
      end else begin
         nwr = 0;
         for (int p = 0; p < NP; p++) begin
            c = mcmd(p);
            a = mbus_ack[p];
            bc = (c == 3) || (c == 4);
            s_aw = 0; s_sp = 0; s_to = 0; s_dr = 0;
            s_il = (c > 4) || (ccmd(p) > 4);
            if (c == 1) nwr++;
            if (m_acked[p]) begin
               s_aw = a;
               m_acked[p] = 0;
            end else if (m_pend[p]) begin
               s_to = (m_age[p] == TO);
               if (a) begin
                  m_pend[p] = 0; m_acked[p] = 1;
                  if (m_cnt[p] < (1 << SW) - 1) m_cnt[p]++;
               end else if (c != m_pcmd[p]) begin
                  s_dr = 1; m_pend[p] = 0;
               end else begin
                  m_age[p]++;
               end
            end else begin
               if (bc && a) begin
                  m_acked[p] = 1;
                  if (m_cnt[p] < (1 << SW) - 1) m_cnt[p]++;
               end else if (bc) begin
                  m_pend[p] = 1; m_pcmd[p] = c; m_age[p] = 1;
               end else if (a) begin
                  s_sp = 1;
               end
            end
            e_aw[p] = s_aw | (e_aw[p] & ~clr);
            e_sp[p] = s_sp | (e_sp[p] & ~clr);
            e_to[p] = s_to | (e_to[p] & ~clr);
            e_dr[p] = s_dr | (e_dr[p] & ~clr);
            e_il[p] = s_il | (e_il[p] & ~clr);
         end
         e_wm = (nwr > 1) | (e_wm & ~clr);
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [NP*SW-1:0] e_stat;
      for (int p = 0; p < NP; p++)
         e_stat[p*SW +: SW] = STATS ? SW'(m_cnt[p]) : '0;
      chk("m_ack_width", 64'(aw), 64'(e_aw));
      chk("m_spurious", 64'(sp), 64'(e_sp));
      chk("m_timeout", 64'(tmo), 64'(e_to));
      chk("m_cmd_drop", 64'(dr), 64'(e_dr));
      chk("m_illegal", 64'(il), 64'(e_il));
      chk("m_wr_multi", 64'(wm), 64'(e_wm));
      chk("m_any", 64'(any),
          64'(|{e_aw, e_sp, e_to, e_dr, e_il, e_wm}));
      chk("m_stat", 64'(stat), 64'(e_stat));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setm(input int p, input int c);
      mbus_cmd[p*MW +: MW] = MW'(c);
   endtask

   task automatic seta(input int p, input bit v);
      mbus_ack[p] = v;
   endtask

   task automatic setc(input int p, input int c);
      cbus_cmd[p*CW +: CW] = CW'(c);
   endtask

   task automatic clear_all();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   initial begin
      int r;
      rst = 1'b1;
      mbus_cmd = '0; mbus_ack = '0; cbus_cmd = '0; clr = 1'b0;
      tick(2);
      chk("reset_any", 64'(any), 64'd0);
      chk("reset_stat", 64'(stat), 64'd0);
      rst = 1'b0;
      tick(1);

      // Port 1 broadcast, ack 3 cycles later for one cycle.
      setm(1, 3);
      tick(3);
      seta(1, 1);
      tick(1);
      seta(1, 0); setm(1, 0);
      tick(1);
      chk("bcast_no_err", 64'(any), 64'd0);
      chk("bcast_stat1", 64'(stat[1*SW +: SW]), STATS ? 64'd1 : 64'd0);

`ifdef MESI_ISC_MON_STATS_EN
      for (int i = 0; i < 20; i++) begin
         setm(1, 3); seta(1, 1);
         tick(1);
         setm(1, 0); seta(1, 0);
         tick(1);
      end
      chk("stat_saturate", 64'(stat[1*SW +: SW]), 64'd15);
`endif

      // Port 0 ack held for two cycles.
      setm(0, 4); seta(0, 1);
      tick(1);
      setm(0, 0);
      tick(1);
      seta(0, 0);
      chk("ack_width", 64'(aw), 64'b0001);
      chk("ack_width_any", 64'(any), 64'd1);
      clear_all();
      chk("ack_width_clr", 64'(aw), 64'd0);

      // Port 2 timeout with no ack, then a late ack.
      setm(2, 3);
      tick(TO);
      chk("timeout_early", 64'(tmo), 64'd0);
      tick(1);
      chk("timeout_rise", 64'(tmo), 64'b0100);
      tick(3);
      seta(2, 1);
      tick(1);
      seta(2, 0); setm(2, 0);
      tick(1);
      chk("timeout_hold", 64'(tmo), 64'b0100);
      chk("late_ack_aw", 64'(aw), 64'd0);
      chk("late_ack_dr", 64'(dr), 64'd0);
      clear_all();
      chk("timeout_clr", 64'(any), 64'd0);

      // Ack at TIMEOUT_CYCLES-1 is still on time.
      setm(2, 4);
      tick(TO - 1);
      seta(2, 1);
      tick(1);
      seta(2, 0); setm(2, 0);
      tick(TO + 2);
      chk("ack_on_time", 64'(any), 64'd0);

      // Port 3 withdraws its broadcast.
      setm(3, 4);
      tick(2);
      setm(3, 0);
      tick(1);
      chk("cmd_drop", 64'(dr), 64'b1000);
      seta(3, 1);
      tick(1);
      seta(3, 0);
      chk("drop_then_idle", 64'(sp), 64'b1000);
      clear_all();

      // Two plain writes plus an illegal cbus command.
      setm(0, 1); setm(1, 1); setc(2, 6);
      tick(1);
      setm(0, 0); setm(1, 0); setc(2, 0);
      chk("wr_multi", 64'(wm), 64'd1);
      chk("illegal_cbus", 64'(il), 64'b0100);
      clear_all();
      chk("wr_multi_clr", 64'(any), 64'd0);

      // Reset in the middle of a handshake, then set beats clear.
      setm(0, 3);
      tick(2);
      rst = 1'b1;
      #1;
      chk("rst_any", 64'(any), 64'd0);
      chk("rst_stat", 64'(stat), 64'd0);
      setm(0, 0);
      tick(1);
      rst = 1'b0;
      clr = 1'b1; seta(0, 1);
      tick(1);
      clr = 1'b0; seta(0, 0);
      chk("set_over_clr", 64'(sp), 64'b0001);
      tick(TO + 2);
      chk("rst_no_timeout", 64'(tmo), 64'd0);
      clear_all();

      // Randomised traffic with sticky commands and sparse acks.
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(7) == 0) begin
               r = int'($urandom_range(15));
               setm(p, (r < 12) ? (r % 5) : (5 + r % 3));
            end
            seta(p, $urandom_range(9) == 0);
            if ($urandom_range(31) == 0) setc(p, int'($urandom_range(7)));
            else setc(p, int'($urandom_range(4)));
         end
         clr = ($urandom_range(15) == 0);
         rst = ($urandom_range(199) == 0);
         tick(1);
      end
      rst = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
